// File: rtl/clock_rate_gen_if.sv
// Control and output bundle of clock_rate_gen: run/clear requests in, divided levels and ticks out.
// The reference clock and reset stay plain ports on the divider itself.
interface clock_rate_gen_if;
   logic EN;
   logic SYNC_CLR;
   logic CLK_FAST;
   logic CLK_2HZ;
   logic CLK_1HZ;
   logic CLK_BLINK;
   logic TICK_FAST;
   logic TICK_2HZ;
   logic TICK_1HZ;

   modport master (
      output EN, SYNC_CLR,
      input  CLK_FAST, CLK_2HZ, CLK_1HZ, CLK_BLINK, TICK_FAST, TICK_2HZ, TICK_1HZ
   );

   modport slave (
      input  EN, SYNC_CLR,
      output CLK_FAST, CLK_2HZ, CLK_1HZ, CLK_BLINK, TICK_FAST, TICK_2HZ, TICK_1HZ
   );
endinterface

// File: rtl/clock_rate_gen.sv
// Exact-ratio divider producing display-mux, 2 Hz, 1 Hz and blink levels plus single-cycle ticks,
// all as registers in the CLK_REF domain, with run enable and synchronous phase clear.
module clock_rate_gen #(
   parameter int REF_HZ     = 100_000_000,
   parameter int FAST_HZ    = 500,
   parameter int BLINK_HZ   = 4,
   parameter int BLINK_DUTY = 50
) (
   input  logic            CLK_REF,
   input  logic            CLK_RES_N,
   clock_rate_gen_if.slave bus
);

   localparam int     D_F    = REF_HZ / (2 * FAST_HZ);
   localparam int     D_Q    = REF_HZ / 4;
   localparam int     D_B    = REF_HZ / BLINK_HZ;
   localparam longint B_ON_L = (longint'(D_B) * longint'(BLINK_DUTY)) / 64'sd100;
   localparam int     B_ON   = int'(B_ON_L);

   localparam int W_F = (D_F > 1) ? $clog2(D_F) : 1;
   localparam int W_Q = (D_Q > 1) ? $clog2(D_Q) : 1;
   localparam int W_B = (D_B > 1) ? $clog2(D_B) : 1;

   localparam logic [W_F-1:0] F_LAST = W_F'(D_F - 1);
   localparam logic [W_Q-1:0] Q_LAST = W_Q'(D_Q - 1);
   localparam logic [W_B-1:0] B_LAST = W_B'(D_B - 1);
   localparam logic [W_B-1:0] B_ON_V = W_B'(B_ON);

   if ((REF_HZ % (4 * FAST_HZ)) != 0) begin : g_err_fast
      $error("clock_rate_gen: REF_HZ must be a multiple of 4*FAST_HZ");
   end
   if ((REF_HZ % BLINK_HZ) != 0) begin : g_err_blink
      $error("clock_rate_gen: REF_HZ must be a multiple of BLINK_HZ");
   end
   if ((BLINK_DUTY < 1) || (BLINK_DUTY > 99) || (B_ON == 0)) begin : g_err_duty
      $error("clock_rate_gen: BLINK_DUTY must be 1..99 and give a non-zero high time");
   end

   logic [W_F-1:0] r_fast_cnt;
   logic [W_Q-1:0] r_q_cnt;
   logic [W_B-1:0] r_blink_cnt;
   logic           r_clk_fast;
   logic           r_clk_2hz;
   logic           r_clk_1hz;
   logic           r_clk_blink;
   logic           r_tick_fast;
   logic           r_tick_2hz;
   logic           r_tick_1hz;

   logic           w_fast_tc;
   logic           w_q_tc;
   logic           w_blink_tc;
   logic [W_F-1:0] w_fast_cnt_nxt;
   logic [W_Q-1:0] w_q_cnt_nxt;
   logic [W_B-1:0] w_blink_cnt_nxt;

   always_comb begin
      w_fast_tc       = (r_fast_cnt == F_LAST);
      w_q_tc          = (r_q_cnt == Q_LAST);
      w_blink_tc      = (r_blink_cnt == B_LAST);
      w_fast_cnt_nxt  = w_fast_tc  ? '0 : r_fast_cnt + 1'b1;
      w_q_cnt_nxt     = w_q_tc     ? '0 : r_q_cnt + 1'b1;
      w_blink_cnt_nxt = w_blink_tc ? '0 : r_blink_cnt + 1'b1;
   end

   always_ff @(posedge CLK_REF or negedge CLK_RES_N) begin
      if (!CLK_RES_N) begin
         r_fast_cnt  <= '0;
         r_q_cnt     <= '0;
         r_blink_cnt <= '0;
         r_clk_fast  <= 1'b0;
         r_clk_2hz   <= 1'b0;
         r_clk_1hz   <= 1'b0;
         r_clk_blink <= 1'b0;
         r_tick_fast <= 1'b0;
         r_tick_2hz  <= 1'b0;
         r_tick_1hz  <= 1'b0;
      end else if (bus.SYNC_CLR) begin
         r_fast_cnt  <= '0;
         r_q_cnt     <= '0;
         r_blink_cnt <= '0;
         r_clk_fast  <= 1'b0;
         r_clk_2hz   <= 1'b0;
         r_clk_1hz   <= 1'b0;
         r_clk_blink <= 1'b0;
         r_tick_fast <= 1'b0;
         r_tick_2hz  <= 1'b0;
         r_tick_1hz  <= 1'b0;
      end else if (bus.EN) begin
         r_fast_cnt  <= w_fast_cnt_nxt;
         r_q_cnt     <= w_q_cnt_nxt;
         r_blink_cnt <= w_blink_cnt_nxt;
         // Blink level looks ahead at the count it will show, so the high phase starts right after clear.
         r_clk_blink <= (w_blink_cnt_nxt < B_ON_V);
         r_tick_fast <= w_fast_tc & ~r_clk_fast;
         if (w_fast_tc) r_clk_fast <= ~r_clk_fast;
         r_tick_2hz  <= w_q_tc & ~r_clk_2hz;
         if (w_q_tc) r_clk_2hz <= ~r_clk_2hz;
         // 1 Hz advances only on the quarter event that takes 2 Hz low, keeping the two phase-locked.
         r_tick_1hz  <= w_q_tc & r_clk_2hz & ~r_clk_1hz;
         if (w_q_tc && r_clk_2hz) r_clk_1hz <= ~r_clk_1hz;
      end else begin
         r_tick_fast <= 1'b0;
         r_tick_2hz  <= 1'b0;
         r_tick_1hz  <= 1'b0;
      end
   end

   assign bus.CLK_FAST  = r_clk_fast;
   assign bus.CLK_2HZ   = r_clk_2hz;
   assign bus.CLK_1HZ   = r_clk_1hz;
   assign bus.CLK_BLINK = r_clk_blink;
   assign bus.TICK_FAST = r_tick_fast;
   assign bus.TICK_2HZ  = r_tick_2hz;
   assign bus.TICK_1HZ  = r_tick_1hz;

endmodule

// File: tb/tb_clock_rate_gen.sv
// Bench for clock_rate_gen at REF_HZ=40, FAST_HZ=10, BLINK_HZ=4, BLINK_DUTY=30 (D_F=2, D_Q=10, D_B=10, B_ON=3).
// Expected outputs come from a closed-form function of the number of enabled edges since clear/reset.
module tb_clock_rate_gen;

   logic clk;
   logic rst_n;

   clock_rate_gen_if bus ();

   clock_rate_gen #(
      .REF_HZ    (40),
      .FAST_HZ   (10),
      .BLINK_HZ  (4),
      .BLINK_DUTY(30)
   ) dut (
      .CLK_REF  (clk),
      .CLK_RES_N(rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         k;
      logic [6:0] exp;  // {FAST, 2HZ, 1HZ, BLINK, TICK_FAST, TICK_2HZ, TICK_1HZ}
   } vec_t;

   int         checks   = 0;
   int         failures = 0;
   int         k        = 0;
   logic [6:0] sb_q[$];
   logic [6:0] prev_out = '0;
   logic       skip_assert = 1'b1;

   function automatic logic [6:0] model(input int kk, input logic act);
      logic fast, f2, f1, bl, tf, t2, t1;
      fast = ((kk / 2) % 2) == 1;
      f2   = ((kk / 10) % 2) == 1;
      f1   = ((kk / 20) % 2) == 1;
      bl   = (kk != 0) && ((kk % 10) < 3);
      tf   = act && ((kk % 4) == 2);
      t2   = act && ((kk % 20) == 10);
      t1   = act && ((kk % 40) == 20);
      return {fast, f2, f1, bl, tf, t2, t1};
   endfunction

   function automatic logic [6:0] dut_out();
      return {bus.CLK_FAST, bus.CLK_2HZ, bus.CLK_1HZ, bus.CLK_BLINK,
              bus.TICK_FAST, bus.TICK_2HZ, bus.TICK_1HZ};
   endfunction

   task automatic check_vec(input string name, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s k=%0d got=%b expected=%b", name, k, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic step(input logic en, input logic clr);
      logic [6:0] got, exp;
      bus.EN       = en;
      bus.SYNC_CLR = clr;
      if (clr) k = 0;
      else if (en) k++;
      sb_q.push_back(model(k, en && !clr));
      @(posedge clk);
      #1;
      got = dut_out();
      if (sb_q.size() == 0) begin
         check_int("scoreboard_empty", 0, 1);
      end else begin
         exp = sb_q.pop_front();
         check_vec("cycle", got, exp);
      end
      if (!clr && !skip_assert) begin
         assert ((got[4] == prev_out[4]) || (prev_out[5] && !got[5])) else begin
            failures++;
            $display("FAIL assert_1hz_on_2hz_fall k=%0d 1hz %b->%b 2hz %b->%b",
                     k, prev_out[4], got[4], prev_out[5], got[5]);
         end
      end
      skip_assert = 1'b0;
      prev_out    = got;
   endtask

   vec_t vecs[10];
   logic blink_hist[0:200];

   initial begin
      int tf_cnt, t2_cnt, t1_cnt, align_err, n, r_fast, r_2, r_1;
      int b_hi, first_low;
      logic [6:0] hold;

      vecs[0] = '{1,  7'b0001000};
      vecs[1] = '{2,  7'b1001100};
      vecs[2] = '{3,  7'b1000000};
      vecs[3] = '{4,  7'b0000000};
      vecs[4] = '{9,  7'b0000000};
      vecs[5] = '{10, 7'b1101110};
      vecs[6] = '{19, 7'b1100000};
      vecs[7] = '{20, 7'b0011001};
      vecs[8] = '{30, 7'b1111110};
      vecs[9] = '{40, 7'b0001000};

      rst_n        = 1'b0;
      bus.EN       = 1'b0;
      bus.SYNC_CLR = 1'b0;
      #23;
      check_vec("reset_state", dut_out(), 7'b0);
      rst_n = 1'b1;
      k = 0;

      // Scenario 1: timing after reset release against hand-derived vectors.
      for (int i = 0; i < 10; i++) begin
         while (k < vecs[i].k) step(1'b1, 1'b0);
         check_vec("vector", dut_out(), vecs[i].exp);
      end

      // Scenario 5: clear while disabled with every level high, then re-measure first rises.
      while (k < 70) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check_vec("levels_high_before_clr", dut_out() & 7'b1111000, 7'b1111000);
      step(1'b0, 1'b1);
      check_vec("after_sync_clr", dut_out(), 7'b0);
      r_fast = -1; r_2 = -1; r_1 = -1;
      for (int i = 1; i <= 45; i++) begin
         step(1'b1, 1'b0);
         if (r_fast < 0 && bus.CLK_FAST) r_fast = i;
         if (r_2 < 0 && bus.CLK_2HZ) r_2 = i;
         if (r_1 < 0 && bus.CLK_1HZ) r_1 = i;
      end
      check_int("fast_first_rise", r_fast, 2);
      check_int("2hz_first_rise", r_2, 10);
      check_int("1hz_first_rise", r_1, 20);

      // Scenario 2/3: 200 cycles of tick counting and blink pattern.
      step(1'b1, 1'b1);
      tf_cnt = 0; t2_cnt = 0; t1_cnt = 0; align_err = 0;
      blink_hist[0] = bus.CLK_BLINK;
      for (int i = 1; i <= 200; i++) begin
         hold = prev_out;
         step(1'b1, 1'b0);
         tf_cnt += int'(bus.TICK_FAST);
         t2_cnt += int'(bus.TICK_2HZ);
         t1_cnt += int'(bus.TICK_1HZ);
         if (bus.TICK_FAST != (bus.CLK_FAST && !hold[6])) align_err++;
         if (bus.TICK_2HZ  != (bus.CLK_2HZ  && !hold[5])) align_err++;
         if (bus.TICK_1HZ  != (bus.CLK_1HZ  && !hold[4])) align_err++;
         blink_hist[i] = bus.CLK_BLINK;
      end
      check_int("tick_fast_count", tf_cnt, 50);
      check_int("tick_2hz_count", t2_cnt, 10);
      check_int("tick_1hz_count", t1_cnt, 5);
      check_int("tick_alignment_errors", align_err, 0);
      b_hi = 0; first_low = -1;
      for (int i = 10; i < 20; i++) begin
         b_hi += int'(blink_hist[i]);
         if (first_low < 0 && !blink_hist[i]) first_low = i;
      end
      check_int("blink_high_cycles", b_hi, 3);
      check_int("blink_first_low", first_low, 13);
      check_int("blink_rehigh", int'(blink_hist[20]), 1);

      // Scenario 4: pause 7 cycles at q_cnt=5.
      step(1'b1, 1'b1);
      n = 0;
      for (int i = 0; i < 5; i++) begin step(1'b1, 1'b0); n++; end
      hold = dut_out();
      tf_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0);
         n++;
         tf_cnt += int'(bus.TICK_FAST) + int'(bus.TICK_2HZ) + int'(bus.TICK_1HZ);
      end
      check_vec("pause_hold_levels", dut_out(), hold & 7'b1111000);
      check_int("pause_ticks", tf_cnt, 0);
      r_2 = -1;
      while (r_2 < 0 && n < 40) begin
         step(1'b1, 1'b0);
         n++;
         if (bus.CLK_2HZ) r_2 = n;
      end
      check_int("2hz_rise_after_pause", r_2, 17);

      // Scenario 6: async reset between edges.
      while (k < 10) step(1'b1, 1'b0);
      check_vec("levels_before_async_rst", dut_out() & 7'b1100000, 7'b1100000);
      #3 rst_n = 1'b0;
      #1 check_vec("async_reset_immediate", dut_out(), 7'b0);
      #2 rst_n = 1'b1;
      k = 0;
      prev_out = '0;
      skip_assert = 1'b1;
      for (int i = 0; i < 25; i++) step(1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
